// File: rtl/mfcc_stage_sequencer.sv
// mfcc_stage_sequencer
//   Frame-level scheduler for the MFCC pipeline. Walks one frame through
//   window buffer -> Hamming -> FFT -> MEL -> DCT. It issues a one-cycle start
//   pulse as each stage is entered and consumes that stage's done pulse. It also
//   commands the window hop and counts completed frames. A per-stage watchdog
//   aborts a stalled frame, and sticky flags report watchdog expiry and PCM FIFO
//   overrun.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   enable_i          level: keep processing frames while high
//   window_ready_i    pulse: window buffer holds a full frame
//   fifo_full_i       PCM FIFO full flag (overrun supervision)
//   *_done_i          per-stage completion pulses
//   clr_flags_i       pulse: clear overrun_o / timeout_o
//   start_*_o         one-cycle start pulses (start_move_o = window hop)
//   frame_valid_o     pulse: one frame of coefficients complete
//   frame_count_o     completed-frame counter, wraps silently
//   busy_o            high while a compute stage is active
//   state_o           current state encoding
//   overrun_o         sticky FIFO overrun flag
//   timeout_o         sticky watchdog flag
//   timeout_stage_o   state of the stage that was aborted last
//
// All outputs come directly from flops. Start pulses are therefore computed
// from the next-state decision, so that each pulse is high exactly in the first
// cycle of its state.

module mfcc_stage_sequencer #(
  parameter int TIMEOUT_CYCLES  = 65535,
  parameter int TIMEOUT_WIDTH   = 16,
  parameter int FRAME_CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable_i,
  input  logic                       window_ready_i,
  input  logic                       fifo_full_i,
  input  logic                       hamming_done_i,
  input  logic                       fft_done_i,
  input  logic                       mel_done_i,
  input  logic                       dct_done_i,
  input  logic                       clr_flags_i,
  output logic                       start_hamming_o,
  output logic                       start_move_o,
  output logic                       start_fft_o,
  output logic                       start_mel_o,
  output logic                       start_dct_o,
  output logic                       frame_valid_o,
  output logic [FRAME_CNT_WIDTH-1:0] frame_count_o,
  output logic                       busy_o,
  output logic [2:0]                 state_o,
  output logic                       overrun_o,
  output logic                       timeout_o,
  output logic [2:0]                 timeout_stage_o
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_WIN = 3'd1,
    ST_HAMMING  = 3'd2,
    ST_FFT      = 3'd3,
    ST_MEL      = 3'd4,
    ST_DCT      = 3'd5
  } state_t;

  // The watchdog fires when the counter sits at this value with no done.
  localparam logic [TIMEOUT_WIDTH-1:0] WDOG_LIMIT = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

  state_t                     state_q,         state_d;
  logic [TIMEOUT_WIDTH-1:0]   wdog_q,          wdog_d;
  logic                       start_hamming_q, start_hamming_d;
  logic                       start_move_q,    start_move_d;
  logic                       start_fft_q,     start_fft_d;
  logic                       start_mel_q,     start_mel_d;
  logic                       start_dct_q,     start_dct_d;
  logic                       frame_valid_q,   frame_valid_d;
  logic [FRAME_CNT_WIDTH-1:0] frame_count_q,   frame_count_d;
  logic                       busy_q,          busy_d;
  logic                       overrun_q,       overrun_d;
  logic                       timeout_q,       timeout_d;
  logic [2:0]                 timeout_stage_q, timeout_stage_d;

  logic is_compute_s;
  logic stage_done_s;
  logic wdog_expired_s;
  logic timeout_set_s;

  // Classify the current state and select the done input that belongs to it.
  always_comb begin
    is_compute_s = 1'b0;
    stage_done_s = 1'b0;
    case (state_q)
      ST_HAMMING: begin
        is_compute_s = 1'b1;
        stage_done_s = hamming_done_i;
      end
      ST_FFT: begin
        is_compute_s = 1'b1;
        stage_done_s = fft_done_i;
      end
      ST_MEL: begin
        is_compute_s = 1'b1;
        stage_done_s = mel_done_i;
      end
      ST_DCT: begin
        is_compute_s = 1'b1;
        stage_done_s = dct_done_i;
      end
      default: begin
        is_compute_s = 1'b0;
        stage_done_s = 1'b0;
      end
    endcase
    // A done arriving in the expiry cycle takes priority over the abort.
    wdog_expired_s = is_compute_s && (wdog_q == WDOG_LIMIT) && !stage_done_s;
  end

  // Next-state logic and next values of the start/frame outputs.
  always_comb begin
    state_d         = state_q;
    start_hamming_d = 1'b0;
    start_move_d    = 1'b0;
    start_fft_d     = 1'b0;
    start_mel_d     = 1'b0;
    start_dct_d     = 1'b0;
    frame_valid_d   = 1'b0;
    frame_count_d   = frame_count_q;
    timeout_set_s   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // window_ready_i is intentionally not remembered here.
        if (enable_i) begin
          state_d = ST_WAIT_WIN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_WIN: begin
        if (!enable_i) begin
          state_d = ST_IDLE;
        end else if (window_ready_i) begin
          state_d         = ST_HAMMING;
          start_hamming_d = 1'b1;
        end else begin
          state_d = ST_WAIT_WIN;
        end
      end
      ST_HAMMING: begin
        if (stage_done_s) begin
          // The window may hop as soon as Hamming has consumed the frame.
          state_d      = ST_FFT;
          start_fft_d  = 1'b1;
          start_move_d = 1'b1;
        end else if (wdog_expired_s) begin
          state_d       = ST_IDLE;
          timeout_set_s = 1'b1;
        end else begin
          state_d = ST_HAMMING;
        end
      end
      ST_FFT: begin
        if (stage_done_s) begin
          state_d     = ST_MEL;
          start_mel_d = 1'b1;
        end else if (wdog_expired_s) begin
          state_d       = ST_IDLE;
          timeout_set_s = 1'b1;
        end else begin
          state_d = ST_FFT;
        end
      end
      ST_MEL: begin
        if (stage_done_s) begin
          state_d     = ST_DCT;
          start_dct_d = 1'b1;
        end else if (wdog_expired_s) begin
          state_d       = ST_IDLE;
          timeout_set_s = 1'b1;
        end else begin
          state_d = ST_MEL;
        end
      end
      ST_DCT: begin
        if (stage_done_s) begin
          // A frame in flight always completes; enable_i is only
          // consulted here to decide whether to wait for another one.
          frame_valid_d = 1'b1;
          frame_count_d = frame_count_q + FRAME_CNT_WIDTH'(1);
          if (enable_i) begin
            state_d = ST_WAIT_WIN;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (wdog_expired_s) begin
          state_d       = ST_IDLE;
          timeout_set_s = 1'b1;
        end else begin
          state_d = ST_DCT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Watchdog counter, busy flag and sticky supervision flags.
  always_comb begin
    wdog_d          = wdog_q;
    busy_d          = 1'b0;
    overrun_d       = overrun_q;
    timeout_d       = timeout_q;
    timeout_stage_d = timeout_stage_q;

    if (state_d != state_q) begin
      wdog_d = '0;
    end else if (is_compute_s) begin
      wdog_d = wdog_q + TIMEOUT_WIDTH'(1);
    end else begin
      wdog_d = '0;
    end

    if ((state_d == ST_HAMMING) || (state_d == ST_FFT) ||
        (state_d == ST_MEL) || (state_d == ST_DCT)) begin
      busy_d = 1'b1;
    end else begin
      busy_d = 1'b0;
    end

    // Set conditions take priority over a simultaneous clear.
    if (fifo_full_i && enable_i) begin
      overrun_d = 1'b1;
    end else if (clr_flags_i) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end

    if (timeout_set_s) begin
      timeout_d       = 1'b1;
      timeout_stage_d = state_q;
    end else if (clr_flags_i) begin
      timeout_d       = 1'b0;
      timeout_stage_d = timeout_stage_q;
    end else begin
      timeout_d       = timeout_q;
      timeout_stage_d = timeout_stage_q;
    end
  end

  // State and output registers; reset aborts any frame in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      wdog_q          <= '0;
      start_hamming_q <= 1'b0;
      start_move_q    <= 1'b0;
      start_fft_q     <= 1'b0;
      start_mel_q     <= 1'b0;
      start_dct_q     <= 1'b0;
      frame_valid_q   <= 1'b0;
      frame_count_q   <= '0;
      busy_q          <= 1'b0;
      overrun_q       <= 1'b0;
      timeout_q       <= 1'b0;
      timeout_stage_q <= 3'd0;
    end else begin
      state_q         <= state_d;
      wdog_q          <= wdog_d;
      start_hamming_q <= start_hamming_d;
      start_move_q    <= start_move_d;
      start_fft_q     <= start_fft_d;
      start_mel_q     <= start_mel_d;
      start_dct_q     <= start_dct_d;
      frame_valid_q   <= frame_valid_d;
      frame_count_q   <= frame_count_d;
      busy_q          <= busy_d;
      overrun_q       <= overrun_d;
      timeout_q       <= timeout_d;
      timeout_stage_q <= timeout_stage_d;
    end
  end

  assign start_hamming_o = start_hamming_q;
  assign start_move_o    = start_move_q;
  assign start_fft_o     = start_fft_q;
  assign start_mel_o     = start_mel_q;
  assign start_dct_o     = start_dct_q;
  assign frame_valid_o   = frame_valid_q;
  assign frame_count_o   = frame_count_q;
  assign busy_o          = busy_q;
  assign state_o         = state_q;
  assign overrun_o       = overrun_q;
  assign timeout_o       = timeout_q;
  assign timeout_stage_o = timeout_stage_q;

endmodule

// File: tb/tb_mfcc_stage_sequencer.sv
// Bench for mfcc_stage_sequencer. It uses a short watchdog (8 cycles) and a
// 2-bit frame counter, so that expiry and wrap-around are reached quickly.
module tb_mfcc_stage_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable_i = 1'b0, window_ready_i = 1'b0, fifo_full_i = 1'b0;
  logic       hamming_done_i = 1'b0, fft_done_i = 1'b0, mel_done_i = 1'b0, dct_done_i = 1'b0;
  logic       clr_flags_i = 1'b0;
  logic       start_hamming_o, start_move_o, start_fft_o, start_mel_o, start_dct_o;
  logic       frame_valid_o, busy_o, overrun_o, timeout_o;
  logic [1:0] frame_count_o;
  logic [2:0] state_o, timeout_stage_o;

  int n_total = 0;
  int n_pass  = 0;

  mfcc_stage_sequencer #(
    .TIMEOUT_CYCLES (8),
    .TIMEOUT_WIDTH  (4),
    .FRAME_CNT_WIDTH(2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable_i       (enable_i),
    .window_ready_i (window_ready_i),
    .fifo_full_i    (fifo_full_i),
    .hamming_done_i (hamming_done_i),
    .fft_done_i     (fft_done_i),
    .mel_done_i     (mel_done_i),
    .dct_done_i     (dct_done_i),
    .clr_flags_i    (clr_flags_i),
    .start_hamming_o(start_hamming_o),
    .start_move_o   (start_move_o),
    .start_fft_o    (start_fft_o),
    .start_mel_o    (start_mel_o),
    .start_dct_o    (start_dct_o),
    .frame_valid_o  (frame_valid_o),
    .frame_count_o  (frame_count_o),
    .busy_o         (busy_o),
    .state_o        (state_o),
    .overrun_o      (overrun_o),
    .timeout_o      (timeout_o),
    .timeout_stage_o(timeout_stage_o)
  );

  always #5 clk = ~clk;

  // Inputs {en, rdy, ham_done, fft_done, mel_done, dct_done}; expected
  // outputs after the edge: state, starts {ham, move, fft, mel, dct}, fv, busy, count.
  typedef struct packed {
    logic [5:0] in;
    logic [2:0] st;
    logic [4:0] starts;
    logic       fv;
    logic       busy;
    logic [1:0] cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mkv(input logic [5:0] in, input logic [2:0] st,
                               input logic [4:0] starts, input logic fv,
                               input logic busy, input logic [1:0] cnt);
    vec_t v;
    v.in = in; v.st = st; v.starts = starts; v.fv = fv; v.busy = busy; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] core_outs();
    return {state_o, start_hamming_o, start_move_o, start_fft_o, start_mel_o,
            start_dct_o, frame_valid_o, busy_o, frame_count_o};
  endfunction

  task automatic pulse_rdy(); window_ready_i = 1'b1; step(); window_ready_i = 1'b0; endtask
  task automatic pulse_hd();  hamming_done_i = 1'b1; step(); hamming_done_i = 1'b0; endtask
  task automatic pulse_fd();  fft_done_i = 1'b1;     step(); fft_done_i = 1'b0;     endtask
  task automatic pulse_md();  mel_done_i = 1'b1;     step(); mel_done_i = 1'b0;     endtask
  task automatic pulse_dd();  dct_done_i = 1'b1;     step(); dct_done_i = 1'b0;     endtask

  // One full frame with every done arriving in the first cycle of its state.
  task automatic run_frame();
    pulse_rdy(); pulse_hd(); pulse_fd(); pulse_md(); pulse_dd();
  endtask

  initial begin
    // Main frame with done pulses five cycles apart, followed by stray inputs.
    tbl.push_back(mkv(6'b000000, 3'd0, 5'b00000, 1'b0, 1'b0, 2'd0));
    tbl.push_back(mkv(6'b100000, 3'd1, 5'b00000, 1'b0, 1'b0, 2'd0));
    tbl.push_back(mkv(6'b110000, 3'd2, 5'b10000, 1'b0, 1'b1, 2'd0));
    for (int i = 0; i < 5; i++) tbl.push_back(mkv(6'b100000, 3'd2, 5'b00000, 1'b0, 1'b1, 2'd0));
    tbl.push_back(mkv(6'b101000, 3'd3, 5'b01100, 1'b0, 1'b1, 2'd0));
    for (int i = 0; i < 4; i++) tbl.push_back(mkv(6'b100000, 3'd3, 5'b00000, 1'b0, 1'b1, 2'd0));
    tbl.push_back(mkv(6'b100100, 3'd4, 5'b00010, 1'b0, 1'b1, 2'd0));
    for (int i = 0; i < 4; i++) tbl.push_back(mkv(6'b100000, 3'd4, 5'b00000, 1'b0, 1'b1, 2'd0));
    tbl.push_back(mkv(6'b100010, 3'd5, 5'b00001, 1'b0, 1'b1, 2'd0));
    for (int i = 0; i < 4; i++) tbl.push_back(mkv(6'b100000, 3'd5, 5'b00000, 1'b0, 1'b1, 2'd0));
    tbl.push_back(mkv(6'b100001, 3'd1, 5'b00000, 1'b1, 1'b0, 2'd1));
    tbl.push_back(mkv(6'b100000, 3'd1, 5'b00000, 1'b0, 1'b0, 2'd1));
    tbl.push_back(mkv(6'b100101, 3'd1, 5'b00000, 1'b0, 1'b0, 2'd1)); // stray dones
    tbl.push_back(mkv(6'b000000, 3'd0, 5'b00000, 1'b0, 1'b0, 2'd1)); // enable drop
    tbl.push_back(mkv(6'b010000, 3'd0, 5'b00000, 1'b0, 1'b0, 2'd1)); // ready in IDLE
    tbl.push_back(mkv(6'b100000, 3'd1, 5'b00000, 1'b0, 1'b0, 2'd1));
    tbl.push_back(mkv(6'b100000, 3'd1, 5'b00000, 1'b0, 1'b0, 2'd1)); // ready not kept

    // Reset state
    #12;
    chk("reset_outputs", {core_outs(), overrun_o, timeout_o, timeout_stage_o}, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    step();

    foreach (tbl[i]) begin
      {enable_i, window_ready_i, hamming_done_i, fft_done_i, mel_done_i, dct_done_i} = tbl[i].in;
      step();
      chk($sformatf("vec%0d", i), {20'h0, core_outs()},
          {20'h0, tbl[i].st, tbl[i].starts, tbl[i].fv, tbl[i].busy, tbl[i].cnt});
    end
    {enable_i, window_ready_i, hamming_done_i, fft_done_i, mel_done_i, dct_done_i} = 6'b100000;

    // Watchdog expiry in FFT (done accepted in the first Hamming cycle).
    pulse_rdy();
    pulse_hd();
    chk("to_enter_fft", {29'h0, state_o}, 32'd3);
    for (int i = 0; i < 7; i++) step();
    chk("to_before_expiry", {28'h0, state_o, timeout_o}, {28'h0, 3'd3, 1'b0});
    step();
    chk("to_expired", {22'h0, state_o, timeout_o, timeout_stage_o, frame_count_o, frame_valid_o},
        {22'h0, 3'd0, 1'b1, 3'd3, 2'd1, 1'b0});
    clr_flags_i = 1'b1; step(); clr_flags_i = 1'b0;
    chk("to_clear", {25'h0, state_o, timeout_o, timeout_stage_o}, {25'h0, 3'd1, 1'b0, 3'd3});

    // fft_done on the exact expiry cycle wins.
    pulse_rdy();
    pulse_hd();
    for (int i = 0; i < 7; i++) step();
    pulse_fd();
    chk("done_at_expiry", {27'h0, state_o, timeout_o, start_mel_o}, {27'h0, 3'd4, 1'b0, 1'b1});

    // Dropping enable during MEL still completes the frame.
    enable_i = 1'b0;
    step();
    chk("dis_in_mel", {29'h0, state_o}, 32'd4);
    pulse_md();
    chk("dis_dct_start", {28'h0, state_o, start_dct_o}, {28'h0, 3'd5, 1'b1});
    pulse_dd();
    chk("dis_frame_done", {26'h0, state_o, frame_valid_o, frame_count_o}, {26'h0, 3'd0, 1'b1, 2'd2});
    step();
    chk("dis_idle", {28'h0, state_o, frame_valid_o}, {28'h0, 3'd0, 1'b0});

    // Overrun flag: needs enable; set beats clear.
    fifo_full_i = 1'b1; step();
    chk("ovr_disabled", {31'h0, overrun_o}, 32'd0);
    enable_i = 1'b1; step(); fifo_full_i = 1'b0;
    chk("ovr_set", {31'h0, overrun_o}, 32'd1);
    step();
    chk("ovr_sticky", {31'h0, overrun_o}, 32'd1);
    clr_flags_i = 1'b1; fifo_full_i = 1'b1; step();
    chk("ovr_set_beats_clr", {31'h0, overrun_o}, 32'd1);
    fifo_full_i = 1'b0; step(); clr_flags_i = 1'b0;
    chk("ovr_cleared", {31'h0, overrun_o}, 32'd0);

    // Frame counter wrap 3 -> 0.
    run_frame();
    chk("cnt_3", {29'h0, frame_count_o, frame_valid_o}, {29'h0, 2'd3, 1'b1});
    run_frame();
    chk("cnt_wrap", {26'h0, state_o, frame_count_o, frame_valid_o}, {26'h0, 3'd1, 2'd0, 1'b1});
    run_frame();

    // Asynchronous reset in FFT, then stray dones after release.
    fifo_full_i = 1'b1; step(); fifo_full_i = 1'b0;
    pulse_rdy();
    pulse_hd();
    chk("pre_reset", {25'h0, state_o, start_fft_o, start_move_o, overrun_o, frame_count_o, busy_o},
        {25'h0, 3'd3, 1'b1, 1'b1, 1'b1, 2'd1, 1'b1});
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset", {core_outs(), overrun_o, timeout_o, timeout_stage_o}, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    hamming_done_i = 1'b1; fft_done_i = 1'b1; dct_done_i = 1'b1;
    step();
    chk("release_stray", {20'h0, core_outs()}, {20'h0, 3'd1, 5'b00000, 1'b0, 1'b0, 2'd0});
    hamming_done_i = 1'b0; fft_done_i = 1'b0; dct_done_i = 1'b0;
    step();
    chk("release_idle_wait", {20'h0, core_outs()}, {20'h0, 3'd1, 5'b00000, 1'b0, 1'b0, 2'd0});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
